// File: rtl/ddr_slv_pkg.sv
// Shared types and constants for the DDR AXI stand-in responder.
package ddr_slv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RDATA
  } state_t;

  localparam int BEAT_SHIFT = 3;
  localparam int LEN_W      = 5;

endpackage

// File: rtl/ddr_slv_ram.sv
// Simple dual-port beat RAM: byte-enabled write port, registered read port.
module ddr_slv_ram #(
  parameter int SW = 16,
  parameter int AW = 10
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [8*SW-1:0] i_wdata,
  input  logic [SW-1:0]   i_wstrb,
  input  logic            i_re,
  input  logic [AW-1:0]   i_raddr,
  output logic [8*SW-1:0] o_rdata
);

  logic [8*SW-1:0] r_mem [2**AW];
  logic [8*SW-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < SW; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/ddr_axi_slave.sv
// AXI responder standing in for the DDR controller user port.
// Define DDR_SLV_INIT_DELAY_EN to delay ddr_init_done by INIT_CYCLES.
module ddr_axi_slave
  import ddr_slv_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int MEM_AW          = 10,
  parameter int INIT_CYCLES     = 64
) (
  input  logic                       axi_aclk,
  input  logic                       rst,
  output logic                       ddr_init_done,
  input  logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [3:0]                 axi_awuser_id,
  input  logic [3:0]                 axi_awlen,
  input  logic                       axi_awvalid,
  output logic                       axi_awready,
  input  logic [8*MEM_DQ_WIDTH-1:0]  axi_wdata,
  input  logic [MEM_DQ_WIDTH-1:0]    axi_wstrb,
  output logic                       axi_wready,
  output logic                       axi_bvalid,
  input  logic                       axi_bready,
  input  logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
  input  logic [3:0]                 axi_aruser_id,
  input  logic [3:0]                 axi_arlen,
  input  logic                       axi_arvalid,
  output logic                       axi_arready,
  output logic [8*MEM_DQ_WIDTH-1:0]  axi_rdata,
  output logic [3:0]                 axi_rid,
  output logic                       axi_rlast,
  output logic                       axi_rvalid
);

  localparam int DW = 8 * MEM_DQ_WIDTH;

  state_t            r_state, w_next;
  logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
  logic [MEM_AW-1:0] r_idx, w_idx_nxt;
  logic [3:0]        r_rid, w_rid_nxt;
  logic              r_prio_w, w_prio_nxt;
  logic              r_rvalid, r_rlast;
  logic              w_init;
  logic              w_gnt_w, w_open;
  logic              w_aw_hs, w_ar_hs;
  logic [DW-1:0]     w_q;
  logic              w_unused, w_unused_cfg;

`ifdef DDR_SLV_INIT_DELAY_EN
  localparam int CW = $clog2(INIT_CYCLES + 1);
  logic [CW-1:0] r_icnt;

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      r_icnt <= '0;
    end else if (r_icnt != CW'(INIT_CYCLES)) begin
      r_icnt <= r_icnt + CW'(1);
    end
  end

  assign w_init       = (r_icnt == CW'(INIT_CYCLES));
  assign w_unused_cfg = 1'b0;
`else
  logic r_init;

  always_ff @(posedge axi_aclk) begin
    if (rst) r_init <= 1'b0;
    else     r_init <= 1'b1;
  end

  assign w_init       = r_init;
  assign w_unused_cfg = (INIT_CYCLES != 0);
`endif

  // Hold off new requests until the last read beat has left.
  assign w_gnt_w = axi_awvalid & (~axi_arvalid | r_prio_w);
  assign w_open  = (r_state == S_IDLE) & w_init & ~r_rvalid;
  assign axi_awready = w_open & w_gnt_w;
  assign axi_arready = w_open & ~w_gnt_w;
  assign w_aw_hs = axi_awvalid & axi_awready;
  assign w_ar_hs = axi_arvalid & axi_arready;

  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_idx_nxt  = r_idx;
    w_rid_nxt  = r_rid;
    w_prio_nxt = r_prio_w;
    unique case (r_state)
      S_IDLE: begin
        if (w_aw_hs) begin
          w_next     = S_WDATA;
          w_cnt_nxt  = {1'b0, axi_awlen} + LEN_W'(1);
          w_idx_nxt  = axi_awaddr[MEM_AW+2:BEAT_SHIFT];
          w_prio_nxt = 1'b0;
        end else if (w_ar_hs) begin
          w_next     = S_RDATA;
          w_cnt_nxt  = {1'b0, axi_arlen} + LEN_W'(1);
          w_idx_nxt  = axi_araddr[MEM_AW+2:BEAT_SHIFT];
          w_rid_nxt  = axi_aruser_id;
          w_prio_nxt = 1'b1;
        end
      end
      S_WDATA, S_RDATA: begin
        w_idx_nxt = r_idx + MEM_AW'(1);
        w_cnt_nxt = r_cnt - LEN_W'(1);
        if (r_cnt == LEN_W'(1)) begin
          w_next = (r_state == S_WDATA) ? S_WRESP : S_IDLE;
        end
      end
      S_WRESP: begin
        if (axi_bready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_rid    <= '0;
      r_prio_w <= 1'b1;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_rid    <= w_rid_nxt;
      r_prio_w <= w_prio_nxt;
      r_rvalid <= (r_state == S_RDATA);
      r_rlast  <= (r_state == S_RDATA) && (r_cnt == LEN_W'(1));
    end
  end

  ddr_slv_ram #(
    .SW (MEM_DQ_WIDTH),
    .AW (MEM_AW)
  ) u_ram (
    .i_clk   (axi_aclk),
    .i_we    (r_state == S_WDATA),
    .i_waddr (r_idx),
    .i_wdata (axi_wdata),
    .i_wstrb (axi_wstrb),
    .i_re    (r_state == S_RDATA),
    .i_raddr (r_idx),
    .o_rdata (w_q)
  );

  assign ddr_init_done = w_init;
  assign axi_wready    = (r_state == S_WDATA);
  assign axi_bvalid    = (r_state == S_WRESP);
  assign axi_rvalid    = r_rvalid;
  assign axi_rlast     = r_rlast;
  assign axi_rid       = r_rid;
  assign axi_rdata     = r_rvalid ? w_q : '0;

  assign w_unused = ^{axi_awaddr[CTRL_ADDR_WIDTH-1:MEM_AW+BEAT_SHIFT],
                      axi_awaddr[BEAT_SHIFT-1:0],
                      axi_araddr[CTRL_ADDR_WIDTH-1:MEM_AW+BEAT_SHIFT],
                      axi_araddr[BEAT_SHIFT-1:0],
                      axi_awuser_id, w_unused_cfg};

endmodule

// File: tb/tb_ddr_axi_slave.sv
// Directed self-checking bench for ddr_axi_slave.
module tb_ddr_axi_slave;

  localparam int DW = 128;
`ifdef DDR_SLV_INIT_DELAY_EN
  localparam int INIT_EXP = 64;
`else
  localparam int INIT_EXP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ddr_init_done;
  logic [27:0]   axi_awaddr;
  logic [3:0]    axi_awuser_id;
  logic [3:0]    axi_awlen;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [DW-1:0] axi_wdata;
  logic [15:0]   axi_wstrb;
  logic          axi_wready;
  logic          axi_bvalid;
  logic          axi_bready;
  logic [27:0]   axi_araddr;
  logic [3:0]    axi_aruser_id;
  logic [3:0]    axi_arlen;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [3:0]    axi_rid;
  logic          axi_rlast;
  logic          axi_rvalid;

  int checks   = 0;
  int failures = 0;
  int ovl      = 0;

  logic [DW-1:0] wbuf [16];
  logic [DW-1:0] rbuf [16];
  int w_beats, r_beats, r_lat;
  bit w_bv_ok, w_to, r_rid_ok, r_last_ok, r_to;

  always #5 clk = ~clk;

  ddr_axi_slave dut (
    .axi_aclk      (clk),
    .rst           (rst),
    .ddr_init_done (ddr_init_done),
    .axi_awaddr    (axi_awaddr),
    .axi_awuser_id (axi_awuser_id),
    .axi_awlen     (axi_awlen),
    .axi_awvalid   (axi_awvalid),
    .axi_awready   (axi_awready),
    .axi_wdata     (axi_wdata),
    .axi_wstrb     (axi_wstrb),
    .axi_wready    (axi_wready),
    .axi_bvalid    (axi_bvalid),
    .axi_bready    (axi_bready),
    .axi_araddr    (axi_araddr),
    .axi_aruser_id (axi_aruser_id),
    .axi_arlen     (axi_arlen),
    .axi_arvalid   (axi_arvalid),
    .axi_arready   (axi_arready),
    .axi_rdata     (axi_rdata),
    .axi_rid       (axi_rid),
    .axi_rlast     (axi_rlast),
    .axi_rvalid    (axi_rvalid)
  );

  always @(negedge clk) begin
    if ((axi_awready && axi_arready) ||
        (axi_wready && axi_rvalid) ||
        ((axi_awready || axi_arready) &&
         (axi_wready || axi_bvalid || axi_rvalid)))
      ovl++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [27:0] a, input logic [3:0] len,
                             input logic [15:0] strb, input int hold);
    int n;
    w_beats = 0; w_bv_ok = 0; w_to = 0;
    axi_awaddr = a; axi_awlen = len; axi_awuser_id = 4'h3;
    axi_awvalid = 1'b1;
    #1;
    n = 0;
    while (!axi_awready && n < 200) begin tick; n++; end
    if (!axi_awready) begin w_to = 1; axi_awvalid = 1'b0; return; end
    tick;
    axi_awvalid = 1'b0;
    n = 0;
    while (n < 40) begin
      if (axi_wready) begin
        axi_wdata = wbuf[w_beats % 16];
        axi_wstrb = strb;
        w_beats++;
        tick;
      end else begin
        w_bv_ok = axi_bvalid;
        break;
      end
      n++;
    end
    if (!axi_bvalid) begin w_to = 1; return; end
    repeat (hold) begin tick; if (!axi_bvalid) w_bv_ok = 0; end
    axi_bready = 1'b1;
    tick;
    axi_bready = 1'b0;
    if (axi_bvalid) w_bv_ok = 0;
  endtask

  task automatic read_burst(input logic [27:0] a, input logic [3:0] len,
                            input logic [3:0] id);
    int n;
    r_beats = 0; r_rid_ok = 1; r_last_ok = 1; r_to = 0; r_lat = 0;
    axi_araddr = a; axi_arlen = len; axi_aruser_id = id;
    axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!axi_arready && n < 200) begin tick; n++; end
    if (!axi_arready) begin r_to = 1; axi_arvalid = 1'b0; return; end
    tick;
    axi_arvalid = 1'b0;
    r_lat = 1;
    while (!axi_rvalid && r_lat < 10) begin tick; r_lat++; end
    if (!axi_rvalid) begin r_to = 1; return; end
    while (axi_rvalid && r_beats < 40) begin
      rbuf[r_beats % 16] = axi_rdata;
      if (axi_rid !== id) r_rid_ok = 0;
      if (axi_rlast !== (r_beats == int'(len))) r_last_ok = 0;
      r_beats++;
      tick;
    end
  endtask

  task automatic test_reset;
    int n;
    bit bad;
    rst = 1'b1; axi_awvalid = 1'b1;
    repeat (3) tick;
    checks++; if (ddr_init_done !== 1'b0) begin failures++; $display("FAIL rst_init got=%b exp=0", ddr_init_done); end
    checks++; if (axi_awready !== 1'b0) begin failures++; $display("FAIL rst_awready got=%b exp=0", axi_awready); end
    checks++; if (axi_arready !== 1'b0) begin failures++; $display("FAIL rst_arready got=%b exp=0", axi_arready); end
    checks++; if (axi_wready !== 1'b0) begin failures++; $display("FAIL rst_wready got=%b exp=0", axi_wready); end
    checks++; if (axi_bvalid !== 1'b0) begin failures++; $display("FAIL rst_bvalid got=%b exp=0", axi_bvalid); end
    checks++; if (axi_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", axi_rvalid); end
    checks++; if (axi_rlast !== 1'b0) begin failures++; $display("FAIL rst_rlast got=%b exp=0", axi_rlast); end
    checks++; if (axi_rid !== 4'h0) begin failures++; $display("FAIL rst_rid got=%h exp=0", axi_rid); end
    checks++; if (axi_rdata !== '0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", axi_rdata); end
    rst = 1'b0;
    n = 0; bad = 0;
    while (!ddr_init_done && n < 200) begin
      if (axi_awready || axi_arready) bad = 1;
      tick;
      n++;
    end
    axi_awvalid = 1'b0;
    checks++; if (n != INIT_EXP) begin failures++; $display("FAIL init_latency got=%0d exp=%0d", n, INIT_EXP); end
    checks++; if (bad) begin failures++; $display("FAIL ready_before_init got=1 exp=0"); end
  endtask

  task automatic test_arbitration;
    byte g;
    string exp = "WRWR";
    for (int i = 0; i < 2; i++) wbuf[i] = DW'(128'hC0 + i);
    ovl = 0;
    axi_awaddr = 28'h300; axi_awlen = 4'd1; axi_awvalid = 1'b1;
    axi_araddr = 28'h300; axi_arlen = 4'd1; axi_arvalid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      axi_awvalid = 1'b1; axi_arvalid = 1'b1;
      #1;
      g = axi_awready ? "W" : (axi_arready ? "R" : "-");
      checks++; if (g != exp[k]) begin failures++; $display("FAIL arb_grant%0d got=%c exp=%c", k, g, exp[k]); end
      if (g == "W") begin
        write_burst(28'h300, 4'd1, 16'hFFFF, 0);
        axi_awvalid = 1'b1;
      end else begin
        read_burst(28'h300, 4'd1, 4'h5);
        axi_arvalid = 1'b1;
        checks++;
        if (r_beats != 2 || rbuf[0] !== DW'(128'hC0) || rbuf[1] !== DW'(128'hC1)) begin
          failures++; $display("FAIL arb_rdata got=%0d/%h/%h exp=2/c0/c1", r_beats, rbuf[0], rbuf[1]);
        end
      end
    end
    axi_awvalid = 1'b0; axi_arvalid = 1'b0;
    tick;
    checks++; if (ovl != 0) begin failures++; $display("FAIL arb_overlap got=%0d exp=0", ovl); end
  endtask

  task automatic test_burst;
    bit ok;
    for (int i = 0; i < 16; i++) wbuf[i] = DW'(i);
    write_burst(28'h40, 4'd15, 16'hFFFF, 0);
    checks++; if (w_to) begin failures++; $display("FAIL wr_timeout got=1 exp=0"); end
    checks++; if (w_beats != 16) begin failures++; $display("FAIL wr_beats got=%0d exp=16", w_beats); end
    checks++; if (!w_bv_ok) begin failures++; $display("FAIL wr_bvalid got=0 exp=1"); end
    read_burst(28'h40, 4'd15, 4'hA);
    checks++; if (r_lat != 2) begin failures++; $display("FAIL rd_latency got=%0d exp=2", r_lat); end
    checks++; if (r_beats != 16) begin failures++; $display("FAIL rd_beats got=%0d exp=16", r_beats); end
    checks++; if (!r_rid_ok) begin failures++; $display("FAIL rd_rid got=0 exp=1"); end
    checks++; if (!r_last_ok) begin failures++; $display("FAIL rd_rlast got=0 exp=1"); end
    ok = 1;
    for (int i = 0; i < 16; i++) if (rbuf[i] !== DW'(i)) ok = 0;
    checks++; if (!ok) begin failures++; $display("FAIL rd_data got=%h exp=%h", rbuf[7], DW'(7)); end
  endtask

  task automatic test_strobe;
    logic [DW-1:0] e;
    wbuf[0] = '1;
    write_burst(28'h200, 4'd0, 16'hFFFF, 0);
    wbuf[0] = {16{8'h5A}};
    write_burst(28'h200, 4'd0, 16'h0001, 2);
    checks++; if (!w_bv_ok) begin failures++; $display("FAIL strb_bhold got=0 exp=1"); end
    read_burst(28'h200, 4'd0, 4'h1);
    e = {{15{8'hFF}}, 8'h5A};
    checks++; if (r_beats != 1 || rbuf[0] !== e) begin failures++; $display("FAIL strb_data got=%h exp=%h", rbuf[0], e); end
    checks++; if (!r_last_ok) begin failures++; $display("FAIL strb_rlast got=0 exp=1"); end
  endtask

  task automatic test_wrap;
    bit ok;
    for (int i = 0; i < 4; i++) wbuf[i] = DW'(128'hA0 + i);
    write_burst(28'h1FF0, 4'd3, 16'hFFFF, 0);
    checks++; if (w_beats != 4) begin failures++; $display("FAIL wrap_wbeats got=%0d exp=4", w_beats); end
    read_burst(28'h1FF0, 4'd3, 4'h2);
    ok = (r_beats == 4);
    for (int i = 0; i < 4; i++) if (rbuf[i] !== DW'(128'hA0 + i)) ok = 0;
    checks++; if (!ok) begin failures++; $display("FAIL wrap_rd got=%h exp=%h", rbuf[2], DW'(128'hA2)); end
    read_burst(28'h2000, 4'd1, 4'h2);
    checks++;
    if (r_beats != 2 || rbuf[0] !== DW'(128'hA2) || rbuf[1] !== DW'(128'hA3)) begin
      failures++; $display("FAIL wrap_alias got=%h/%h exp=a2/a3", rbuf[0], rbuf[1]);
    end
  endtask

  task automatic test_reset_mid_read;
    int n;
    bit ok;
    axi_araddr = 28'h40; axi_arlen = 4'd15; axi_aruser_id = 4'h6;
    axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!axi_arready && n < 200) begin tick; n++; end
    tick;
    axi_arvalid = 1'b0;
    n = 0;
    while (!axi_rvalid && n < 10) begin tick; n++; end
    repeat (5) tick;
    checks++; if (axi_rvalid !== 1'b1 || axi_rdata !== DW'(5)) begin failures++; $display("FAIL mid_beat5 got=%b/%h exp=1/5", axi_rvalid, axi_rdata); end
    rst = 1'b1;
    tick;
    checks++; if (axi_rvalid !== 1'b0) begin failures++; $display("FAIL mid_rvalid got=%b exp=0", axi_rvalid); end
    checks++; if (axi_rlast !== 1'b0 || axi_rid !== 4'h0) begin failures++; $display("FAIL mid_rlast_rid got=%b/%h exp=0/0", axi_rlast, axi_rid); end
    checks++;
    if (axi_awready || axi_arready || axi_wready || axi_bvalid) begin
      failures++; $display("FAIL mid_handshake got=%b%b%b%b exp=0000", axi_awready, axi_arready, axi_wready, axi_bvalid);
    end
    rst = 1'b0;
    read_burst(28'h40, 4'd15, 4'h9);
    ok = (r_beats == 16) && !r_to && r_rid_ok && r_last_ok;
    for (int i = 0; i < 16; i++) if (rbuf[i] !== DW'(i)) ok = 0;
    checks++; if (!ok) begin failures++; $display("FAIL mid_reread got=%0d beats exp=16", r_beats); end
  endtask

  initial begin
    rst = 1'b1;
    axi_awaddr = '0; axi_awuser_id = '0; axi_awlen = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_bready = 1'b0;
    axi_araddr = '0; axi_aruser_id = '0; axi_arlen = '0; axi_arvalid = 1'b0;
    test_reset;
    test_arbitration;
    test_burst;
    test_strobe;
    test_wrap;
    test_reset_mid_read;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_axi_slave.md
# ddr_axi_slave

Synthesizable AXI responder that stands in for the DDR controller's user-side AXI port, answering the write and read bursts issued by `Frame_top`. It stores beats in an on-chip byte-enabled RAM and follows the controller's handshake convention: no `wvalid` and no `rready`. Data moves on slave-driven `wready` and `rvalid`. It lets the frame buffer path run on boards or benches without the DDR IP, and drives `ddr_init_done` the same way the controller does.

## Interface
Parameters:
- `CTRL_ADDR_WIDTH`, 28, address width in MEM_DQ_WIDTH-bit units
- `MEM_DQ_WIDTH`, 16, DQ width; beat width is 8*MEM_DQ_WIDTH, strobe width is MEM_DQ_WIDTH
- `MEM_AW`, 10, log2 of RAM depth in beats
- `INIT_CYCLES`, 64, cycles from reset release to `ddr_init_done` (used only with the macro)

Ports:
- `axi_aclk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `ddr_init_done`  out  1  responder ready
- `axi_awaddr`  in  CTRL_ADDR_WIDTH  write burst start address
- `axi_awuser_id`  in  4  write ID
- `axi_awlen`  in  4  write beats minus 1
- `axi_awvalid`  in  1 / `axi_awready`  out  1  write address handshake
- `axi_wdata`  in  8*MEM_DQ_WIDTH  write beat
- `axi_wstrb`  in  MEM_DQ_WIDTH  byte enables
- `axi_wready`  out  1  beat sampled this cycle
- `axi_bvalid`  out  1 / `axi_bready`  in  1  write response handshake
- `axi_araddr`  in  CTRL_ADDR_WIDTH / `axi_aruser_id`  in  4 / `axi_arlen`  in  4  read request
- `axi_arvalid`  in  1 / `axi_arready`  out  1  read address handshake
- `axi_rdata`  out  8*MEM_DQ_WIDTH / `axi_rid`  out  4 / `axi_rlast`  out  1 / `axi_rvalid`  out  1  read beat stream

## Operation
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE to WDATA:
  - Taken on an AW handshake.
  - Latches the beat count `awlen+1` (1..16).
  - Latches the start index `awaddr[MEM_AW+2:3]`; each beat covers 8 address units.
- IDLE to RDATA: taken on an AR handshake; latches the ID, count and index the same way.
- Arbitration in IDLE when both `awvalid` and `arvalid` are high:
  - Round-robin: the channel not granted last time wins.
  - After reset, write wins.
  - A lone valid request wins immediately.
- `awready` and `arready` are combinational:
  - Asserted only when the state is IDLE, `ddr_init_done` is high and that channel has the grant.
  - Never both high in the same cycle.
- WDATA:
  - `wready` is high for exactly len+1 consecutive cycles.
  - Each cycle, the RAM word at the current index is written with per-byte `wstrb`.
  - The index increments every beat and wraps modulo 2^MEM_AW.
  - Then go to WRESP.
- WRESP: `bvalid` is high and held until `bready`; then go to IDLE.
- RDATA:
  - len+1 contiguous `rvalid` beats with no gaps, since there is no backpressure.
  - `rid` equals the latched ID on every beat.
  - `rlast` is high only on the final beat.
  - Then go to IDLE.
- Address bits above MEM_AW+2 are ignored, so addresses alias.
- RAM contents are not cleared by `rst`; the RAM powers up to zero.
- `rst` asserted mid-burst: the next cycle is IDLE with all handshake outputs low; a partially written burst keeps the beats already written.

## Timing
- Reset values: `ddr_init_done` 0, `axi_awready` 0, `axi_arready` 0, `axi_wready` 0, `axi_bvalid` 0, `axi_rvalid` 0, `axi_rlast` 0, `axi_rid` 0, `axi_rdata` 0.
- Write burst, with the AW handshake at cycle T:
  - `wready` high T+1..T+1+len.
  - `bvalid` high from T+2+len.
  - The next handshake is possible the cycle after `bvalid && bready`.
- Read burst, with the AR handshake at cycle T:
  - RAM is read from T+1 onward (synchronous read).
  - `rvalid` high T+2..T+2+len.
  - The next handshake is possible at T+3+len.
- Read-after-write to the same index returns the new data, because the write completes before `bvalid`.

## Configuration
- `DDR_SLV_INIT_DELAY_EN` defined: `ddr_init_done` rises INIT_CYCLES cycles after the first cycle with `rst` low. A counter saturates; the output stays high until `rst`.
- Not defined: `ddr_init_done` rises on the first cycle after `rst` is released, and INIT_CYCLES is unused.

## Structure
- Package `ddr_slv_pkg`:
  - State enum.
  - `BEAT_SHIFT = 3`.
  - Burst-length width constant (5 bits, holding 1..16).
- Sub-module `ddr_slv_ram`: simple dual-port RAM with byte write-enable, one write port and one synchronous-read port, depth 2^MEM_AW.

## Test plan
- Reset release, macro defined, INIT_CYCLES=64: `ddr_init_done` is 0 for 64 cycles, then 1; `awready` and `arready` stay 0 before that.
- Write `awaddr=0x40`, `awlen=15`, `wdata` = beat number, `wstrb` all ones: 16 `wready` cycles, then `bvalid`. Read `araddr=0x40`, `arlen=15`: `rdata` 0..15, `rlast` on beat 15, `rid` = request ID.
- Write with `wstrb=0x0001` over an existing all-ones word: readback changes only byte 0.
- `awvalid` and `arvalid` held high together over 4 bursts: grants alternate W,R,W,R with no overlapping data phases.
- Burst starting at index 2^MEM_AW-2, len=3: the last two beats land at indices 0 and 1; readback is consistent.
- `rst` pulsed during beat 5 of a 16-beat read: `rvalid` is 0 the next cycle, the FSM is in IDLE, and a new AR is accepted once `ddr_init_done` returns.
